demultiplexer_1to3_reg: RTL
===========================

Name: demultiplexer_1to3_reg

Overview:
Registered 1-to-3 demultiplexer. It is the distribution-side counterpart of the datapath 3-to-1 selector. One source stream with a valid/ready handshake is routed by a 2-bit Selector to one of three destination channels. Each channel has a one-entry output register and its own valid/ready pair. Used where a single producer (e.g. write-back data) feeds three consumers that can stall independently.

Parameters:
NBits, 32, data width of input and each output channel
CntBits, 8, width of the saturating drop counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Selector  input  2  destination: 2'b00 ch0, 2'b01 ch1, 2'b10 ch2, 2'b11 invalid
In_Valid  input  1  source presents Data_In/Selector
In_Ready  output  1  block accepts the current beat (combinational)
Data_In  input  NBits  source data
Valid0/Valid1/Valid2  output  1 each  channel k holds valid data
Ready0/Ready1/Ready2  input  1 each  consumer k takes data this cycle
Data0/Data1/Data2  output  NBits each  channel k data register
Drop_Count  output  CntBits  number of beats accepted with Selector=2'b11
Error  output  1  sticky flag: at least one invalid-selector beat seen

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. All state is cleared on the falling edge of reset, independent of clk.
- Reset values: Valid0..2=0, Data0..2=0, Drop_Count=0, Error=0. A beat in flight when reset asserts is lost.
- Accept condition: a beat transfers on a rising clk edge when In_Valid & In_Ready.
- In_Ready for Selector=k (k=0..2): !Validk | Readyk, so a full channel can drain and refill in the same cycle.
- In_Ready for Selector=2'b11: 1. The beat is always accepted and then discarded.
- In_Ready is purely combinational from Selector, Validk and Readyk. It does not depend on In_Valid.
- Latency: an accepted beat appears on Datak with Validk=1 on the cycle after acceptance. There is no combinational path from Data_In to Datak.
- Channel k register update each edge:
  - fill (accept to k) & drain (Validk & Readyk): load Data_In, Validk stays 1.
  - fill only: load Data_In, Validk <- 1.
  - drain only: Validk <- 0, Datak retains its last value.
  - neither: hold.
- Stability: while Validk & !Readyk, Datak and Validk must not change.
- Channel independence: all three channels may drain in the same cycle. Only the selected channel can fill.
- Invalid selector: on an accepted beat with Selector=2'b11:
  - Drop_Count increments, saturating at all-ones (no wrap).
  - Error <- 1 and stays set until reset.
  - No channel state changes.
- Selector and Data_In are sampled only on accept. While In_Valid=0 their values are don't-care.

Decomposition:
- Shared package (demux_pkg):
  - selector constants SEL_CH0=2'b00, SEL_CH1=2'b01, SEL_CH2=2'b10, SEL_DROP=2'b11.
  - default widths NBits and CntBits.
- Sub-module channel_slot, instantiated three times:
  - parameter NBits.
  - ports clk, reset, fill, Data_In, Ready, Valid, Data.
  - implements the one-entry register and the fill/drain rules above.
- The top level holds the Selector decode, the In_Ready mux, the drop counter and the Error flag.

Test Plan:
1. Reset release; In_Valid=1, Selector=00, Data_In=32'hA5A5_0001, Ready0=1 -> next cycle Valid0=1, Data0=32'hA5A5_0001, Valid1=Valid2=0.
2. Ready1=0; send 32'h11 to ch1, then hold In_Valid with 32'h22 to ch1 -> In_Ready=0, Data1 stays 32'h11 for 5 cycles. Raise Ready1 -> same edge loads 32'h22, Valid1 remains 1.
3. ch2 stalled full (Ready2=0); send 32'h33 to ch0 -> In_Ready=1, beat accepted, Valid0=1 next cycle, Data2 unchanged.
4. Selector=11 with In_Valid=1 for 300 consecutive cycles (CntBits=8) -> In_Ready=1 every cycle, Drop_Count saturates at 8'hFF, Error=1, all Validk unchanged.
5. Fill all three channels with Ready0..2=0, then raise Ready0..2 in one cycle -> all three Validk drop to 0 on that edge, Datak retain values.
6. Assert reset mid-cycle while Valid1=1 and Error=1 -> Valid0..2, Data0..2, Drop_Count and Error read 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared selector encodings and default widths for the 1-to-3 demux
package demux_pkg;

  localparam logic [1:0] SEL_CH0  = 2'b00;
  localparam logic [1:0] SEL_CH1  = 2'b01;
  localparam logic [1:0] SEL_CH2  = 2'b10;
  localparam logic [1:0] SEL_DROP = 2'b11;

  localparam int NBITS_DEFAULT   = 32;
  localparam int CNTBITS_DEFAULT = 8;

endpackage

// File: rtl/channel_slot.sv
// rtl/channel_slot.sv - one-entry output register with valid/ready drain
module channel_slot
  import demux_pkg::*;
#(
  parameter int NBits = NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fill,
  input  logic [NBits-1:0] Data_In,
  input  logic             Ready,
  output logic             Valid,
  output logic [NBits-1:0] Data
);

  // Fill wins over drain so a full slot can be emptied and reloaded on one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Valid <= 1'b0;
      Data  <= '0;
    end else if (fill) begin
      Valid <= 1'b1;
      Data  <= Data_In;
    end else if (Valid && Ready) begin
      Valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demultiplexer_1to3_reg.sv
// rtl/demultiplexer_1to3_reg.sv - registered 1-to-3 demux with drop counter and sticky error
module demultiplexer_1to3_reg
  import demux_pkg::*;
#(
  parameter int NBits   = NBITS_DEFAULT,
  parameter int CntBits = CNTBITS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Selector,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [NBits-1:0]   Data_In,
  output logic               Valid0,
  output logic               Valid1,
  output logic               Valid2,
  input  logic               Ready0,
  input  logic               Ready1,
  input  logic               Ready2,
  output logic [NBits-1:0]   Data0,
  output logic [NBits-1:0]   Data1,
  output logic [NBits-1:0]   Data2,
  output logic [CntBits-1:0] Drop_Count,
  output logic               Error
);

  logic       accept;
  logic [2:0] fill;

  always_comb begin
    In_Ready = 1'b1;
    case (Selector)
      SEL_CH0: In_Ready = !Valid0 || Ready0;
      SEL_CH1: In_Ready = !Valid1 || Ready1;
      SEL_CH2: In_Ready = !Valid2 || Ready2;
      default: In_Ready = 1'b1;
    endcase
  end

  assign accept  = In_Valid && In_Ready;
  assign fill[0] = accept && (Selector == SEL_CH0);
  assign fill[1] = accept && (Selector == SEL_CH1);
  assign fill[2] = accept && (Selector == SEL_CH2);

  channel_slot #(.NBits(NBits)) u_slot0 (
    .clk(clk), .reset(reset), .fill(fill[0]), .Data_In(Data_In),
    .Ready(Ready0), .Valid(Valid0), .Data(Data0)
  );

  channel_slot #(.NBits(NBits)) u_slot1 (
    .clk(clk), .reset(reset), .fill(fill[1]), .Data_In(Data_In),
    .Ready(Ready1), .Valid(Valid1), .Data(Data1)
  );

  channel_slot #(.NBits(NBits)) u_slot2 (
    .clk(clk), .reset(reset), .fill(fill[2]), .Data_In(Data_In),
    .Ready(Ready2), .Valid(Valid2), .Data(Data2)
  );

  // Dropped beats saturate rather than wrap so a large count never reads as small.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Drop_Count <= '0;
      Error      <= 1'b0;
    end else if (accept && (Selector == SEL_DROP)) begin
      Error <= 1'b1;
      if (Drop_Count != {CntBits{1'b1}}) begin
        Drop_Count <= Drop_Count + CntBits'(1);
      end
    end
  end

endmodule
